hs_ram_arbiter: RTL and testbench

//  Shares the game work-RAM port between the main CPU and the hiscore engine.

---
 rtl/hs_ram_arbiter.sv | 146 ++++++++++++++
 tb/tb_hs_ram_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_ram_arbiter.sv
// Work-RAM port arbiter between the main CPU and the hiscore engine.
// Optional macro HS_ARB_STALL_EN: grant without pause by stalling the CPU via cpu_wait.
module hs_ram_arbiter #(
  parameter int AW          = 11,
  parameter int DW          = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          paused,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_wait,
  input  logic [AW-1:0] hs_address,
  input  logic [DW-1:0] hs_data_in,
  input  logic          hs_write_enable,
  input  logic          hs_read_intent,
  input  logic          hs_write_intent,
  output logic [DW-1:0] hs_data_out,
  output logic          hs_grant,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_CPU,
    ST_DRAIN,
    ST_HS,
    ST_GUARD
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_grant;
  logic          w_hs_req;
  logic          w_start;
  logic          w_cpu_we;

  assign w_hs_req = hs_read_intent | hs_write_intent;

`ifdef HS_ARB_STALL_EN
  logic r_wait;

  // The CPU is stalled instead of paused, so any request may start a grant.
  assign w_start  = w_hs_req;
  assign cpu_wait = r_wait;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wait <= 1'b0;
    end else begin
      r_wait <= (w_state_nxt != ST_CPU);
    end
  end
`else
  assign w_start  = w_hs_req & paused;
  assign cpu_wait = 1'b0;
`endif

  // A stalled CPU may still present a write strobe; it must not reach RAM.
  assign w_cpu_we = cpu_cs & cpu_we & ~cpu_wait;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CPU: begin
        if (w_start) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_state_nxt = ST_HS;
      end
      ST_HS: begin
        if (!w_hs_req) begin
          w_state_nxt = ST_GUARD;
          w_cnt_nxt   = CW'(HOLD_CYCLES - 1);
        end
      end
      ST_GUARD: begin
        if (w_hs_req) begin
          w_state_nxt = ST_HS;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_CPU;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_CPU;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_CPU;
      r_cnt   <= '0;
      r_grant <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= (w_state_nxt == ST_HS);
    end
  end

  assign hs_grant = r_grant;

  // The mux follows the live state so reset hands the port back to the CPU at once.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_we   = w_cpu_we;
    case (r_state)
      ST_HS: begin
        ram_addr = hs_address;
        ram_din  = hs_data_in;
        ram_we   = hs_write_enable;
      end
      ST_GUARD: begin
        ram_addr = hs_address;
        ram_din  = hs_data_in;
        ram_we   = 1'b0;
      end
      default: begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = w_cpu_we;
      end
    endcase
  end

  assign cpu_dout    = ram_dout;
  assign hs_data_out = ram_dout;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Self-checking bench for hs_ram_arbiter: directed scenarios plus randomized
// CPU/hiscore traffic checked against a word-level memory scoreboard.
module tb_hs_ram_arbiter;
  localparam int AW   = 11;
  localparam int DW   = 8;
  localparam int HOLD = 2;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          paused;
  logic          cpu_cs;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_wait;
  logic [AW-1:0] hs_address;
  logic [DW-1:0] hs_data_in;
  logic          hs_write_enable;
  logic          hs_read_intent;
  logic          hs_write_intent;
  logic [DW-1:0] hs_data_out;
  logic          hs_grant;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  logic [AW-1:0] written [$];

  hs_ram_arbiter #(.AW(AW), .DW(DW), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .paused(paused),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
    .hs_address(hs_address), .hs_data_in(hs_data_in),
    .hs_write_enable(hs_write_enable), .hs_read_intent(hs_read_intent),
    .hs_write_intent(hs_write_intent), .hs_data_out(hs_data_out),
    .hs_grant(hs_grant), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous RAM with one-cycle read latency.
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0;
    exp_mem[a] = d;
    written.push_back(a);
  endtask

  task automatic cpu_read_check(input logic [AW-1:0] a, input string name);
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    tick();
    checks++;
    if (cpu_dout !== exp_mem[a]) begin
      failures++;
      $display("FAIL %s addr=%h got=%h exp=%h", name, a, cpu_dout, exp_mem[a]);
    end
    cpu_cs = 1'b0;
  endtask

  task automatic hs_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    hs_address = a; hs_data_in = d; hs_write_enable = 1'b1;
    tick();
    hs_write_enable = 1'b0;
    exp_mem[a] = d;
    written.push_back(a);
  endtask

  task automatic hs_read_check(input logic [AW-1:0] a, input string name);
    hs_address = a;
    tick();
    checks++;
    if (hs_data_out !== exp_mem[a]) begin
      failures++;
      $display("FAIL %s addr=%h got=%h exp=%h", name, a, hs_data_out, exp_mem[a]);
    end
  endtask

  // Request the port while paused: one drain cycle, grant on the second edge.
  task automatic hs_acquire(input logic rd, input string name);
    paused = 1'b1;
    hs_read_intent = rd; hs_write_intent = ~rd;
    tick();
    checks++;
    if (hs_grant !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain grant got=%b exp=0", name, hs_grant);
    end
    tick();
    checks++;
    if (hs_grant !== 1'b1) begin
      failures++;
      $display("FAIL %s_grant grant got=%b exp=1", name, hs_grant);
    end
  endtask

  // Drop the request: the HS cycle, then HOLD guard cycles, then the CPU owns RAM.
  task automatic hs_release(input string name);
    hs_read_intent = 1'b0; hs_write_intent = 1'b0; hs_write_enable = 1'b0;
    cpu_addr = ~hs_address;
    for (int i = 0; i < HOLD + 1; i++) tick();
    checks++;
    if (hs_grant !== 1'b0 || ram_addr !== cpu_addr) begin
      failures++;
      $display("FAIL %s_release grant=%b ram_addr=%h exp grant=0 ram_addr=%h",
               name, hs_grant, ram_addr, cpu_addr);
    end
    paused = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; paused = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_din = '0; hs_address = '0; hs_data_in = '0;
    hs_write_enable = 1'b0; hs_read_intent = 1'b0; hs_write_intent = 1'b0;
    tick(); tick();
    checks++;
    if (hs_grant !== 1'b0 || cpu_wait !== 1'b0 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_state grant=%b wait=%b we=%b exp 0/0/0", hs_grant, cpu_wait, ram_we);
    end
    reset_n = 1'b1;
    tick();
    hs_address = 11'h456;
    hs_acquire(1'b1, "reset_enter");
    cpu_addr = 11'h123;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (hs_grant !== 1'b0 || ram_addr !== 11'h123 || cpu_wait !== 1'b0) begin
      failures++;
      $display("FAIL reset_async grant=%b ram_addr=%h wait=%b exp 0/123/0", hs_grant, ram_addr, cpu_wait);
    end
    tick();
    checks++;
    if (hs_grant !== 1'b0 || ram_addr !== 11'h123) begin
      failures++;
      $display("FAIL reset_edge grant=%b ram_addr=%h exp 0/123", hs_grant, ram_addr);
    end
    hs_read_intent = 1'b0; paused = 1'b0;
    reset_n = 1'b1;
    tick(); tick();
    checks++;
    if (hs_grant !== 1'b0) begin
      failures++;
      $display("FAIL reset_release grant got=%b exp=0", hs_grant);
    end
  endtask

  task automatic test_idle_ownership();
`ifndef HS_ARB_STALL_EN
    int bad = 0;
    paused = 1'b0; hs_read_intent = 1'b1; hs_address = 11'h0AA;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hs_grant !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_no_grant cycles_granted=%0d exp=0", bad);
    end
`endif
    cpu_write(11'h010, 8'h5A);
    cpu_read_check(11'h010, "idle_cpu_rw");
    hs_read_intent = 1'b0;
    tick();
  endtask

  task automatic test_grant_sequence();
    paused = 1'b1; cpu_addr = 11'h7FF; hs_address = 11'h010; hs_read_intent = 1'b1;
    tick();
    checks++;
    if (hs_grant !== 1'b0 || ram_addr !== 11'h7FF) begin
      failures++;
      $display("FAIL grant_drain grant=%b ram_addr=%h exp 0/7ff", hs_grant, ram_addr);
    end
    tick();
    checks++;
    if (hs_grant !== 1'b1 || ram_addr !== 11'h010) begin
      failures++;
      $display("FAIL grant_hs grant=%b ram_addr=%h exp 1/010", hs_grant, ram_addr);
    end
    tick();
    checks++;
    if (hs_data_out !== 8'h5A) begin
      failures++;
      $display("FAIL grant_read got=%h exp=5a", hs_data_out);
    end
    hs_release("grant");
  endtask

  task automatic test_collision();
    paused = 1'b1;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h020; cpu_din = 8'hA5;
    hs_write_intent = 1'b1;
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0;
    exp_mem[11'h020] = 8'hA5;
    written.push_back(11'h020);
    tick();
    checks++;
    if (hs_grant !== 1'b1) begin
      failures++;
      $display("FAIL collision_grant got=%b exp=1", hs_grant);
    end
    hs_write(11'h021, 8'h33);
    hs_read_check(11'h020, "collision_cpu_write");
    hs_read_check(11'h021, "collision_hs_write");
  endtask

  task automatic test_guard();
    cpu_write_pre: begin end
    exp_mem[11'h0F0] = mem[11'h0F0];
    cpu_addr = 11'h300; hs_address = 11'h0F0; hs_data_in = 8'hEE;
    hs_write_intent = 1'b0;
    tick();
    hs_write_enable = 1'b1;
    #1;
    checks++;
    if (hs_grant !== 1'b0 || ram_addr !== 11'h0F0 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL guard_enter grant=%b ram_addr=%h we=%b exp 0/0f0/0", hs_grant, ram_addr, ram_we);
    end
    hs_write_enable = 1'b0; hs_write_intent = 1'b1;
    tick();
    checks++;
    if (hs_grant !== 1'b1 || ram_addr !== 11'h0F0) begin
      failures++;
      $display("FAIL guard_rerequest grant=%b ram_addr=%h exp 1/0f0", hs_grant, ram_addr);
    end
    hs_write_intent = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      tick();
      checks++;
      if (hs_grant !== 1'b0 || ram_addr !== 11'h0F0) begin
        failures++;
        $display("FAIL guard_hold%0d grant=%b ram_addr=%h exp 0/0f0", i, hs_grant, ram_addr);
      end
    end
    tick();
    checks++;
    if (ram_addr !== 11'h300 || hs_grant !== 1'b0) begin
      failures++;
      $display("FAIL guard_cpu_back ram_addr=%h grant=%b exp 300/0", ram_addr, hs_grant);
    end
    paused = 1'b0;
    hs_write_enable = 1'b1; cpu_cs = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      failures++;
      $display("FAIL hs_we_outside_hs got=%b exp=0", ram_we);
    end
    tick();
    hs_write_enable = 1'b0;
    cpu_read_check(11'h0F0, "guard_no_write");
  endtask

  task automatic test_stall();
`ifdef HS_ARB_STALL_EN
    cpu_write(11'h040, 8'h11);
    paused = 1'b0; hs_address = 11'h041; hs_write_intent = 1'b1;
    #1;
    checks++;
    if (cpu_wait !== 1'b0) begin
      failures++;
      $display("FAIL stall_idle wait got=%b exp=0", cpu_wait);
    end
    tick();
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h040; cpu_din = 8'h99;
    #1;
    checks++;
    if (cpu_wait !== 1'b1 || hs_grant !== 1'b0 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain wait=%b grant=%b we=%b exp 1/0/0", cpu_wait, hs_grant, ram_we);
    end
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0;
    checks++;
    if (cpu_wait !== 1'b1 || hs_grant !== 1'b1) begin
      failures++;
      $display("FAIL stall_hs wait=%b grant=%b exp 1/1", cpu_wait, hs_grant);
    end
    hs_write_intent = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      tick();
      checks++;
      if (cpu_wait !== 1'b1) begin
        failures++;
        $display("FAIL stall_guard%0d wait got=%b exp=1", i, cpu_wait);
      end
    end
    tick();
    checks++;
    if (cpu_wait !== 1'b0) begin
      failures++;
      $display("FAIL stall_release wait got=%b exp=0", cpu_wait);
    end
    cpu_read_check(11'h040, "stall_blocked_write");
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int op = $urandom_range(0, 2);
      if (op == 0 || written.size() == 0) begin
        cpu_write(AW'($urandom), DW'($urandom));
      end else if (op == 1) begin
        cpu_read_check(written[$urandom_range(0, written.size() - 1)], "rand_cpu_read");
      end else begin
        hs_acquire(1'($urandom), "rand");
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
          if ($urandom_range(0, 1) == 0)
            hs_write(AW'($urandom), DW'($urandom));
          else
            hs_read_check(written[$urandom_range(0, written.size() - 1)], "rand_hs_read");
        end
        hs_release("rand");
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_ownership();
    test_grant_sequence();
    test_collision();
    test_guard();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
